// File: rtl/booth_encoder_sequencer.sv
// Sequential radix-4 Booth multiplier controller: scans the multiplier two bits
// per cycle, drives the external Booth decoder and accumulates its partial products.
module booth_encoder_sequencer #(
    parameter int STEP_COUNT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplier,
    input  logic [31:0] multiplicand,
    output logic [2:0]  booth_operation,
    output logic [31:0] shifted_multiplicand,
    input  logic [31:0] decoder_output,
    input  logic        decoder_carry,
    output logic        busy,
    output logic [31:0] data_result,
    output logic        data_ready,
    output logic [1:0]  fsm_state
);

    localparam int CW = $clog2(STEP_COUNT);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEP_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [32:0]   mreg;
    logic [31:0]   mcand;
    logic [31:0]   acc;
    logic [CW-1:0] count;
    logic          accept;
    logic          last_step;
    logic [31:0]   acc_sum;

    assign accept    = (state == ST_IDLE) && start;
    assign last_step = (state == ST_RUN) && (count == LAST_STEP);
    // Negative Booth codes arrive as the one's complement plus this carry.
    assign acc_sum   = acc + decoder_output + {31'b0, decoder_carry};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mreg        <= '0;
            mcand       <= '0;
            acc         <= '0;
            count       <= '0;
            data_result <= '0;
        end else if (accept) begin
            mreg  <= {multiplier, 1'b0};
            mcand <= multiplicand;
            acc   <= '0;
            count <= '0;
        end else if (state == ST_RUN) begin
            acc   <= acc_sum;
            // Arithmetic shift keeps the sign bit feeding the upper Booth groups.
            mreg  <= {{2{mreg[32]}}, mreg[32:2]};
            mcand <= mcand << 2;
            count <= count + CW'(1);
            if (last_step) begin
                data_result <= acc_sum;
            end
        end
    end

    always_comb begin
        booth_operation      = 3'b000;
        shifted_multiplicand = '0;
        if (state == ST_RUN) begin
            booth_operation      = mreg[2:0];
            shifted_multiplicand = mcand;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign data_ready = (state == ST_DONE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_booth_encoder_sequencer.sv
// Directed bench for booth_encoder_sequencer with a behavioural Booth decoder model.
module tb_booth_encoder_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] multiplier;
    logic [31:0] multiplicand;
    logic [2:0]  booth_operation;
    logic [31:0] shifted_multiplicand;
    logic [31:0] decoder_output;
    logic        decoder_carry;
    logic        busy;
    logic [31:0] data_result;
    logic        data_ready;
    logic [1:0]  fsm_state;

    int tests;
    int failures;

    booth_encoder_sequencer dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .multiplier           (multiplier),
        .multiplicand         (multiplicand),
        .booth_operation      (booth_operation),
        .shifted_multiplicand (shifted_multiplicand),
        .decoder_output       (decoder_output),
        .decoder_carry        (decoder_carry),
        .busy                 (busy),
        .data_result          (data_result),
        .data_ready           (data_ready),
        .fsm_state            (fsm_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decoder model: negative codes give one's complement with carry-in 1.
    always_comb begin
        decoder_output = '0;
        decoder_carry  = 1'b0;
        case (booth_operation)
            3'b001, 3'b010: decoder_output = shifted_multiplicand;
            3'b011:         decoder_output = shifted_multiplicand << 1;
            3'b100: begin
                decoder_output = ~(shifted_multiplicand << 1);
                decoder_carry  = 1'b1;
            end
            3'b101, 3'b110: begin
                decoder_output = ~shifted_multiplicand;
                decoder_carry  = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: called at a negedge while idle; returns at the negedge of cycle 1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start        = 1'b1;
        multiplier   = a;
        multiplicand = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Walks cycles first_cyc..17 of an operation, then checks the idle cycle 18.
    task automatic follow(input int first_cyc, input logic [31:0] exp, input string tag,
                          input bit pulse_ignored);
        for (int cyc = first_cyc; cyc <= 17; cyc++) begin
            check({tag, "_busy"}, {31'b0, busy}, 32'd1);
            check({tag, "_ready"}, {31'b0, data_ready}, (cyc == 17) ? 32'd1 : 32'd0);
            check({tag, "_state"}, {30'b0, fsm_state}, (cyc == 17) ? 32'd2 : 32'd1);
            if (cyc == 17) check({tag, "_result"}, data_result, exp);
            if (pulse_ignored && (cyc == 5 || cyc == 17)) begin
                start        = 1'b1;
                multiplier   = 32'h0000_DEAD;
                multiplicand = 32'h0000_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_idle_ready"}, {31'b0, data_ready}, 32'd0);
        check({tag, "_held_result"}, data_result, exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        tests        = 0;
        failures     = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (2) @(negedge clock);

        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, data_ready}, 32'd0);
        check("rst_result", data_result, 32'd0);
        check("rst_op", {29'b0, booth_operation}, 32'd0);
        check("rst_shifted", shifted_multiplicand, 32'd0);
        check("rst_state", {30'b0, fsm_state}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 3 x 5: groups 110 (-M) then 001 (+4M), then all zero.
        launch(32'd3, 32'd5);
        check("op_step0", {29'b0, booth_operation}, 32'b110);
        check("sm_step0", shifted_multiplicand, 32'd5);
        @(negedge clock);
        check("op_step1", {29'b0, booth_operation}, 32'b001);
        check("sm_step1", shifted_multiplicand, 32'd20);
        @(negedge clock);
        check("op_step2", {29'b0, booth_operation}, 32'b000);
        check("sm_step2", shifted_multiplicand, 32'd80);
        follow(3, 32'd15, "m3x5", 1'b0);

        launch(32'hFFFF_FFFE, 32'd7);
        follow(1, 32'hFFFF_FFF2, "neg2x7", 1'b0);
        launch(32'd2, 32'h7FFF_FFFF);
        follow(1, 32'hFFFF_FFFE, "ovf", 1'b0);
        launch(32'h0001_0000, 32'h0001_0000);
        follow(1, 32'h0000_0000, "trunc0", 1'b0);
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        follow(1, 32'h8000_0000, "minxneg1", 1'b0);
        launch(32'hFFFF_FFFD, 32'hFFFF_FFFB);
        follow(1, 32'd15, "neg3xneg5", 1'b0);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        follow(1, 32'd1, "neg1sq", 1'b0);

        // Starts in RUN (cycle 5) and DONE (cycle 17) ignored; cycle 18 start accepted.
        launch(32'd6, 32'd9);
        follow(1, 32'h36, "ignored", 1'b1);
        launch(32'd100, 32'hFFFF_FFFF);
        follow(1, 32'hFFFF_FF9C, "b2b", 1'b0);

        // Reset during step 8 aborts without a ready pulse and clears the result.
        launch(32'h55, 32'h3);
        repeat (8) @(negedge clock);
        check("abort_state_run", {30'b0, fsm_state}, 32'd1);
        check("abort_ready_pre", {31'b0, data_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_ready", {31'b0, data_ready}, 32'd0);
        check("abort_op", {29'b0, booth_operation}, 32'd0);
        check("abort_state", {30'b0, fsm_state}, 32'd0);
        launch(32'h1234, 32'h10);
        follow(1, 32'h0001_2340, "post_abort", 1'b0);

        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom;
            launch(a, b);
            follow(1, a * b, "random", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
